axonerve_wordcount_word_unpacker: RTL and testbench

//  Sits between the AXI read master's m_axis stream and the Axonerve CAM search stage in wordcout_top.

---
 rtl/axonerve_wordcount_word_unpacker_if.sv | 13 +
 rtl/axonerve_wordcount_word_unpacker.sv | 144 ++++++++++++++
 tb/tb_axonerve_wordcount_word_unpacker.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axonerve_wordcount_word_unpacker_if.sv
// Generic valid/ready word stream with a last marker; used for the packed
// input beats and for the unpacked word output.
interface axonerve_wordcount_word_unpacker_if #(
    parameter int W = 64
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axonerve_wordcount_word_unpacker.sv
// Splits wide read beats into fixed-width words for the CAM search stage,
// stopping after a programmed word count and draining the rest of the transfer.
module axonerve_wordcount_word_unpacker #(
    parameter int C_DATA_WIDTH  = 512,
    parameter int C_WORD_WIDTH  = 64,
    parameter int C_COUNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     kick,
    input  logic [C_COUNT_WIDTH-1:0] num_of_words,
    output logic                     busy,
    output logic                     done,
    output logic                     short_flag,
    output logic [C_COUNT_WIDTH-1:0] word_count,
    axonerve_wordcount_word_unpacker_if.slave  s_axis,
    axonerve_wordcount_word_unpacker_if.master m_word
);

    localparam int LANES  = C_DATA_WIDTH / C_WORD_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic [C_COUNT_WIDTH-1:0]            limit;
    logic                                vld_p1;
    logic                                last_p1;
    logic [LANE_W-1:0]                   lane_p1;
    logic [LANES-1:0][C_WORD_WIDTH-1:0]  beat_p1;

    logic start_job;
    logic start_zero;
    logic at_last_lane;
    logic final_cnt;
    logic end_word;
    logic word_fire;
    logic beat_load;

    assign start_job    = (state == IDLE) && kick && (num_of_words != '0);
    assign start_zero   = (state == IDLE) && kick && (num_of_words == '0);
    assign at_last_lane = (lane_p1 == LAST_LANE);
    assign final_cnt    = ((word_count + C_COUNT_WIDTH'(1)) == limit);
    // A word ends the job either by reaching the limit or by exhausting a tlast beat.
    assign end_word     = final_cnt || (at_last_lane && last_p1);
    assign word_fire    = m_word.valid && m_word.ready;
    assign beat_load    = (state == RUN) && s_axis.valid && s_axis.ready;

    assign m_word.data  = vld_p1 ? beat_p1[lane_p1] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        s_axis.ready = 1'b0;
        m_word.valid = 1'b0;
        m_word.last  = 1'b0;
        case (state)
            IDLE: begin
                if (start_job) begin
                    state_nxt = RUN;
                end else if (start_zero) begin
                    state_nxt = FIN;
                end
            end
            RUN: begin
                busy         = 1'b1;
                m_word.valid = vld_p1;
                m_word.last  = vld_p1 && end_word;
                // Refill in the same cycle the last lane leaves, so beats stream without a bubble.
                s_axis.ready = !vld_p1 ||
                               (m_word.ready && at_last_lane && !end_word);
                if (vld_p1 && m_word.ready && end_word) begin
                    state_nxt = (final_cnt && !last_p1) ? DRAIN : FIN;
                end
            end
            DRAIN: begin
                busy         = 1'b1;
                s_axis.ready = 1'b1;
                if (s_axis.valid && s_axis.last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limit      <= '0;
            word_count <= '0;
            short_flag <= 1'b0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            lane_p1    <= '0;
        end else begin
            if (start_job) begin
                limit      <= num_of_words;
                word_count <= '0;
                short_flag <= 1'b0;
                vld_p1     <= 1'b0;
                lane_p1    <= '0;
            end
            if (word_fire) begin
                word_count <= word_count + C_COUNT_WIDTH'(1);
                lane_p1    <= lane_p1 + LANE_W'(1);
                if (at_last_lane || end_word) begin
                    vld_p1 <= 1'b0;
                end
                if (at_last_lane && last_p1 && !final_cnt) begin
                    short_flag <= 1'b1;
                end
            end
            // A newly accepted beat overrides the buffer release above.
            if (beat_load) begin
                vld_p1  <= 1'b1;
                last_p1 <= s_axis.last;
                lane_p1 <= '0;
            end
        end
    end

    // ---- stage p1: beat buffer ----
    always_ff @(posedge clk) begin
        if (beat_load) begin
            beat_p1 <= s_axis.data;
        end
    end

endmodule

// File: tb/tb_axonerve_wordcount_word_unpacker.sv
// Directed bench for the word unpacker: a job-level model predicts the word
// sequence, and a per-cycle monitor checks every output handshake against it.
module tb_axonerve_wordcount_word_unpacker;

    localparam int DW    = 512;
    localparam int WW    = 64;
    localparam int CW    = 32;
    localparam int LANES = DW / WW;

    logic          clk = 1'b0;
    logic          reset;
    logic          kick;
    logic [CW-1:0] num_of_words;
    logic          busy;
    logic          done;
    logic          short_flag;
    logic [CW-1:0] word_count;

    axonerve_wordcount_word_unpacker_if #(.W(DW)) s_axis ();
    axonerve_wordcount_word_unpacker_if #(.W(WW)) m_word ();

    axonerve_wordcount_word_unpacker #(
        .C_DATA_WIDTH (DW),
        .C_WORD_WIDTH (WW),
        .C_COUNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .kick        (kick),
        .num_of_words(num_of_words),
        .busy        (busy),
        .done        (done),
        .short_flag  (short_flag),
        .word_count  (word_count),
        .s_axis      (s_axis),
        .m_word      (m_word)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [DW:0]   src_q[$];
    logic [WW:0]   exp_q[$];
    logic [WW:0]   e_word;
    logic          src_fire = 1'b0;
    logic          mon_en = 1'b0;
    logic          held_pending = 1'b0;
    logic [WW-1:0] held_data;
    logic          held_last;
    int            n_out = 0;
    int            model_n = 0;
    logic          model_short = 1'b0;
    int            ready_mode = 0;
    logic          got_first_src = 1'b0;
    logic          got_first_hs = 1'b0;
    time           t_first_src;
    time           t_first_hs;
    time           t_last_hs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] word_val(input int job, input int i);
        return {32'(job), 32'(i)};
    endfunction

    // Job model: words run in beat/lane order up to the first tlast beat,
    // truncated at the programmed count.
    task automatic build_job(input int job, input int num, input int nbeats);
        logic [DW-1:0] bt;
        int total;
        src_q.delete();
        exp_q.delete();
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < LANES; l++) bt[l*WW +: WW] = word_val(job, b*LANES + l);
            src_q.push_back({(b == nbeats-1), bt});
        end
        total       = nbeats * LANES;
        model_n     = (num < total) ? num : total;
        model_short = (num > total);
        for (int i = 0; i < model_n; i++) exp_q.push_back({(i == model_n-1), word_val(job, i)});
    endtask

    initial begin
        s_axis.valid = 1'b0;
        s_axis.data  = '0;
        s_axis.last  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
            src_fire = 1'b0;
            if (src_q.size() > 0) begin
                s_axis.valid = 1'b1;
                {s_axis.last, s_axis.data} = src_q[0];
            end else begin
                s_axis.valid = 1'b0;
                s_axis.last  = 1'b0;
            end
        end
    end

    initial begin
        m_word.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) m_word.ready = 1'b1;
            else                 m_word.ready = ~m_word.ready;
        end
    end

    always @(negedge clk) begin
        src_fire = s_axis.valid && s_axis.ready && !reset;
        if (mon_en && !reset) begin
            if (src_fire && !got_first_src) begin
                got_first_src = 1'b1;
                t_first_src   = $time;
            end
            if (!busy) check("idle_tready", 64'(s_axis.ready), 64'(0));
            if (held_pending) begin
                check("hold_valid", 64'(m_word.valid), 64'(1));
                check("hold_data", m_word.data, held_data);
                check("hold_last", 64'(m_word.last), 64'(held_last));
            end
            if (m_word.valid && s_axis.ready)
                check("tready_gate",
                      64'({m_word.ready, (n_out % LANES) == LANES-1,
                           (exp_q.size() > 0) ? exp_q[0][WW] : 1'b1}),
                      64'(3'b110));
            if (m_word.valid && m_word.ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(exp_q.size()), 64'(1));
                end else begin
                    e_word = exp_q.pop_front();
                    check("word_data", m_word.data, e_word[WW-1:0]);
                    check("word_last", 64'(m_word.last), 64'(e_word[WW]));
                    if (!got_first_hs) begin
                        got_first_hs = 1'b1;
                        t_first_hs   = $time;
                    end
                    if (m_word.last) t_last_hs = $time;
                    n_out++;
                end
                held_pending = 1'b0;
            end else if (m_word.valid) begin
                held_pending = 1'b1;
                held_data    = m_word.data;
                held_last    = m_word.last;
            end else begin
                held_pending = 1'b0;
            end
        end
    end

    task automatic start_kick(input int num);
        @(posedge clk);
        #1;
        num_of_words = CW'(num);
        kick         = 1'b1;
        @(posedge clk);
        #1;
        kick = 1'b0;
    endtask

    task automatic run_job(input int job, input int num, input int nbeats, input int mode,
                           input bit timing, input int exp_cnt, input bit exp_short);
        int k;
        build_job(job, num, nbeats);
        ready_mode    = mode;
        n_out         = 0;
        got_first_src = 1'b0;
        got_first_hs  = 1'b0;
        start_kick(num);
        if (mode == 1) begin
            repeat (3) @(posedge clk);
            #1;
            num_of_words = CW'(3);
            kick         = 1'b1;
            @(posedge clk);
            #1;
            kick = 1'b0;
        end
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 400) begin
            check("done_timeout", 64'(done), 64'(1));
        end else begin
            check("word_count", 64'(word_count), 64'(exp_cnt));
            check("word_count_model", 64'(word_count), 64'(model_n));
            check("short_flag", 64'(short_flag), 64'(exp_short));
            check("short_model", 64'(short_flag), 64'(model_short));
            check("busy_at_done", 64'(busy), 64'(0));
            check("words_left", 64'(exp_q.size()), 64'(0));
            check("beats_left", 64'(src_q.size()), 64'(0));
            check("words_out", 64'(n_out), 64'(exp_cnt));
            if (timing) begin
                check("first_latency", 64'(t_first_hs - t_first_src), 64'(10));
                check("burst_span", 64'(t_last_hs - t_first_hs), 64'((exp_cnt - 1) * 10));
                check("done_delay", 64'($time - t_last_hs), 64'(10));
            end
            @(negedge clk);
            check("done_pulse", 64'(done), 64'(0));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_short"}, 64'(short_flag), 64'(0));
        check({tag, "_count"}, 64'(word_count), 64'(0));
        check({tag, "_mvalid"}, 64'(m_word.valid), 64'(0));
        check({tag, "_mlast"}, 64'(m_word.last), 64'(0));
        check({tag, "_mdata"}, m_word.data, 64'(0));
        check({tag, "_tready"}, 64'(s_axis.ready), 64'(0));
    endtask

    initial begin
        int k;
        reset        = 1'b1;
        kick         = 1'b0;
        num_of_words = '0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Full two-beat job at full rate, with literal spot values for the model.
        run_job(1, 16, 2, 0, 1'b1, 16, 1'b0);
        check("lit_word15", word_val(1, 15), 64'h0000_0001_0000_000F);
        run_job(2, 10, 2, 0, 1'b0, 10, 1'b0);
        run_job(3, 5, 3, 0, 1'b0, 5, 1'b0);
        run_job(4, 20, 1, 0, 1'b0, 8, 1'b1);
        run_job(5, 16, 2, 1, 1'b0, 16, 1'b0);

        // Zero-length job: done one clock after kick, no beat taken.
        ready_mode = 0;
        build_job(6, 0, 1);
        @(posedge clk);
        #1;
        num_of_words = '0;
        kick         = 1'b1;
        @(negedge clk);
        check("zero_done_early", 64'(done), 64'(0));
        @(posedge clk);
        #1;
        kick = 1'b0;
        @(negedge clk);
        check("zero_done", 64'(done), 64'(1));
        check("zero_busy", 64'(busy), 64'(0));
        check("zero_tready", 64'(s_axis.ready), 64'(0));
        @(negedge clk);
        check("zero_done_end", 64'(done), 64'(0));
        check("zero_tready2", 64'(s_axis.ready), 64'(0));
        src_q.delete();
        repeat (2) @(negedge clk);

        // Reset in the middle of a job.
        build_job(7, 16, 2);
        ready_mode = 0;
        n_out      = 0;
        start_kick(16);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (n_out >= 3) break;
        end
        check("reset_setup", 64'(n_out >= 3), 64'(1));
        #2;
        mon_en       = 1'b0;
        reset        = 1'b1;
        #1;
        check_idle_outputs("midreset");
        src_q.delete();
        exp_q.delete();
        held_pending = 1'b0;
        src_fire     = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_done", 64'(done), 64'(0));
            check("post_reset_busy", 64'(busy), 64'(0));
        end
        mon_en = 1'b1;
        run_job(8, 16, 2, 0, 1'b1, 16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
